// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Multi-cycle sequencer for the 16-bit / 4-bit-opcode datapath.
//             It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and
//             shares one memory port between instruction fetch and data
//             access using a req/ack handshake. It also drives the datapath
//             strobes and flags HALT, illegal opcodes and memory timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode_i,
    input  logic       flag_lt_i,
    input  logic       flag_gt_i,
    input  logic       flag_eq_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       mem_fetch_o,
    output logic       ir_write_o,
    output logic       pc_inc_o,
    output logic       pc_load_o,
    output logic       alu_src_o,
    output logic [2:0] alu_op_o,
    output logic       reg_write_o,
    output logic       r15_write_o,
    output logic       mem_to_reg_o,
    output logic       byte_op_o,
    output logic       sign_ext_o,
    output logic       halted_o,
    output logic       fault_o,
    output logic       illegal_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [3:0] c_OP_HALT  = 4'b0000;
    localparam logic [3:0] c_OP_JMP   = 4'b0001;
    localparam logic [3:0] c_OP_BGT   = 4'b0100;
    localparam logic [3:0] c_OP_BLT   = 4'b0101;
    localparam logic [3:0] c_OP_BEQ   = 4'b0110;
    localparam logic [3:0] c_OP_ANDI  = 4'b1000;
    localparam logic [3:0] c_OP_ORI   = 4'b1001;
    localparam logic [3:0] c_OP_LBU   = 4'b1010;
    localparam logic [3:0] c_OP_SB    = 4'b1011;
    localparam logic [3:0] c_OP_LB    = 4'b1100;
    localparam logic [3:0] c_OP_LW    = 4'b1101;
    localparam logic [3:0] c_OP_TYPEA = 4'b1111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_FN  = 3'b100;

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(MEM_TIMEOUT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic w_is_load;
    logic w_is_sb;
    logic w_is_byte;
    logic w_timeout;

    // Opcode class decode shared by the MEM and WB strobes
    always_comb begin
        w_is_load = (opcode_i == c_OP_LBU) || (opcode_i == c_OP_LB) || (opcode_i == c_OP_LW);
        w_is_sb   = (opcode_i == c_OP_SB);
        w_is_byte = (opcode_i == c_OP_LBU) || (opcode_i == c_OP_LB) || w_is_sb;
        w_timeout = (cnt_q == c_TIMEOUT);
    end

    // State and wait-counter registers; reset drops every strobe immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, wait-counter and strobe decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_fetch_o  = 1'b0;
        ir_write_o   = 1'b0;
        pc_inc_o     = 1'b0;
        pc_load_o    = 1'b0;
        alu_src_o    = 1'b0;
        alu_op_o     = c_ALU_ADD;
        reg_write_o  = 1'b0;
        r15_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        byte_op_o    = 1'b0;
        sign_ext_o   = 1'b0;
        halted_o     = 1'b0;
        fault_o      = 1'b0;
        illegal_o    = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req_o   = 1'b1;
                mem_fetch_o = 1'b1;
                if (mem_ack_i) begin
                    ir_write_o = 1'b1;
                    pc_inc_o   = 1'b1;
                    state_d    = S_DECODE;
                end else if (w_timeout) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                case (opcode_i)
                    c_OP_HALT: state_d = S_HALT;
                    c_OP_JMP: begin
                        pc_load_o = 1'b1;
                        state_d   = S_FETCH;
                    end
                    c_OP_TYPEA, c_OP_ANDI, c_OP_ORI, c_OP_LBU, c_OP_SB,
                    c_OP_LB, c_OP_LW, c_OP_BGT, c_OP_BLT, c_OP_BEQ:
                        state_d = S_EXEC;
                    default: begin
                        // Undefined opcodes execute as a NOP
                        illegal_o = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode_i)
                    c_OP_TYPEA: begin
                        alu_op_o = c_ALU_FN;
                        state_d  = S_WB;
                    end
                    c_OP_ANDI: begin
                        alu_op_o  = c_ALU_AND;
                        alu_src_o = 1'b1;
                        state_d   = S_WB;
                    end
                    c_OP_ORI: begin
                        alu_op_o  = c_ALU_OR;
                        alu_src_o = 1'b1;
                        state_d   = S_WB;
                    end
                    c_OP_LBU, c_OP_LB, c_OP_LW, c_OP_SB: begin
                        alu_op_o  = c_ALU_ADD;
                        alu_src_o = 1'b1;
                        state_d   = S_MEM;
                    end
                    c_OP_BGT: begin
                        alu_op_o  = c_ALU_SUB;
                        pc_load_o = flag_gt_i;
                    end
                    c_OP_BLT: begin
                        alu_op_o  = c_ALU_SUB;
                        pc_load_o = flag_lt_i;
                    end
                    c_OP_BEQ: begin
                        alu_op_o  = c_ALU_SUB;
                        pc_load_o = flag_eq_i;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req_o  = 1'b1;
                mem_we_o   = w_is_sb;
                byte_op_o  = w_is_byte;
                sign_ext_o = (opcode_i == c_OP_LB);
                if (mem_ack_i) begin
                    state_d = w_is_sb ? S_FETCH : S_WB;
                end else if (w_timeout) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = w_is_load;
                r15_write_o  = (opcode_i == c_OP_TYPEA);
                byte_op_o    = w_is_byte;
                sign_ext_o   = (opcode_i == c_OP_LB);
                state_d      = S_FETCH;
            end
            S_HALT:  halted_o = 1'b1;
            S_FAULT: fault_o  = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Directed cycle-by-cycle checks of the multicycle sequencer
//             strobes, including wait states, timeouts and async reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic       flag_lt, flag_gt, flag_eq, mem_ack;
    logic       mem_req, mem_we, mem_fetch, ir_write, pc_inc, pc_load, alu_src;
    logic [2:0] alu_op;
    logic       reg_write, r15_write, mem_to_reg, byte_op, sign_ext;
    logic       halted, fault, illegal;
    logic [17:0] outs;

    int errors = 0;
    int checks = 0;

    // Output bit layout used by the expected-value constants below
    localparam logic [17:0] O_REQ  = 18'h20000, O_WE   = 18'h10000, O_MF   = 18'h08000;
    localparam logic [17:0] O_IRW  = 18'h04000, O_PCI  = 18'h02000, O_PCL  = 18'h01000;
    localparam logic [17:0] O_SRC  = 18'h00800, O_SUB  = 18'h00100, O_AND  = 18'h00200;
    localparam logic [17:0] O_OR   = 18'h00300, O_FN   = 18'h00400, O_RW   = 18'h00080;
    localparam logic [17:0] O_R15  = 18'h00040, O_M2R  = 18'h00020, O_BYTE = 18'h00010;
    localparam logic [17:0] O_SEXT = 18'h00008, O_HALT = 18'h00004, O_FLT  = 18'h00002;
    localparam logic [17:0] O_ILL  = 18'h00001;
    localparam logic [17:0] FA = O_REQ | O_MF | O_IRW | O_PCI;
    localparam logic [17:0] FW = O_REQ | O_MF;
    localparam logic [17:0] MLB = O_REQ | O_BYTE | O_SEXT;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode_i    (opcode),
        .flag_lt_i   (flag_lt),
        .flag_gt_i   (flag_gt),
        .flag_eq_i   (flag_eq),
        .mem_ack_i   (mem_ack),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_fetch_o (mem_fetch),
        .ir_write_o  (ir_write),
        .pc_inc_o    (pc_inc),
        .pc_load_o   (pc_load),
        .alu_src_o   (alu_src),
        .alu_op_o    (alu_op),
        .reg_write_o (reg_write),
        .r15_write_o (r15_write),
        .mem_to_reg_o(mem_to_reg),
        .byte_op_o   (byte_op),
        .sign_ext_o  (sign_ext),
        .halted_o    (halted),
        .fault_o     (fault),
        .illegal_o   (illegal)
    );

    assign outs = {mem_req, mem_we, mem_fetch, ir_write, pc_inc, pc_load, alu_src, alu_op,
                   reg_write, r15_write, mem_to_reg, byte_op, sign_ext, halted, fault, illegal};

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic        ack;
        logic [2:0]  flg;   // {lt, gt, eq}
        logic [17:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [3:0] o, input logic a,
                       input logic [2:0] f, input logic [17:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.ack = a; v.flg = f; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: outputs got %05h expected %05h", nm, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check mid-low-phase
    task automatic step(input string nm, input logic r, input logic [3:0] o, input logic a,
                        input logic [2:0] f, input logic [17:0] e);
        rst_n = r; opcode = o; mem_ack = a;
        {flag_lt, flag_gt, flag_eq} = f;
        #2;
        chk(nm, outs, e);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; opcode = 4'h0; mem_ack = 1'b0;
        flag_lt = 1'b0; flag_gt = 1'b0; flag_eq = 1'b0;

        // TypeA then HALT, ack tied high
        add(0,4'h0,0,3'b000,18'h0);
        add(1,4'h0,1,3'b000,18'h0);
        add(1,4'hF,1,3'b000,FA);
        add(1,4'hF,1,3'b000,18'h0);
        add(1,4'hF,1,3'b111,O_FN);
        add(1,4'hF,1,3'b000,O_RW | O_R15);
        add(1,4'h0,1,3'b000,FA);
        add(1,4'h0,1,3'b000,18'h0);
        add(1,4'h0,1,3'b000,O_HALT);
        add(1,4'h0,1,3'b111,O_HALT);
        // LB with three wait states in FETCH and MEM
        add(0,4'hC,0,3'b000,18'h0);
        add(1,4'hC,0,3'b000,18'h0);
        for (int i = 0; i < 3; i++) add(1,4'hC,0,3'b000,FW);
        add(1,4'hC,1,3'b000,FA);
        add(1,4'hC,0,3'b000,18'h0);
        add(1,4'hC,0,3'b000,O_SRC);
        for (int i = 0; i < 3; i++) add(1,4'hC,0,3'b000,MLB);
        add(1,4'hC,1,3'b000,MLB);
        add(1,4'hC,1,3'b000,O_RW | O_M2R | O_BYTE | O_SEXT);
        // Branches: BEQ taken, BEQ not taken, BGT taken, BLT not taken
        add(1,4'h6,1,3'b000,FA); add(1,4'h6,1,3'b000,18'h0); add(1,4'h6,1,3'b001,O_SUB | O_PCL);
        add(1,4'h6,1,3'b000,FA); add(1,4'h6,1,3'b000,18'h0); add(1,4'h6,1,3'b110,O_SUB);
        add(1,4'h4,1,3'b000,FA); add(1,4'h4,1,3'b000,18'h0); add(1,4'h4,1,3'b010,O_SUB | O_PCL);
        add(1,4'h5,1,3'b000,FA); add(1,4'h5,1,3'b000,18'h0); add(1,4'h5,1,3'b011,O_SUB);
        // Undefined opcodes act as NOPs with an illegal pulse
        add(1,4'h7,1,3'b000,FA); add(1,4'h7,1,3'b000,O_ILL);
        add(1,4'hE,1,3'b000,FA); add(1,4'hE,1,3'b000,O_ILL);
        add(1,4'h2,1,3'b000,FA); add(1,4'h2,1,3'b000,O_ILL);
        add(1,4'h3,1,3'b000,FA); add(1,4'h3,1,3'b000,O_ILL);
        // JMP
        add(1,4'h1,1,3'b000,FA); add(1,4'h1,1,3'b000,O_PCL);
        // ANDI, ORI
        add(1,4'h8,1,3'b000,FA); add(1,4'h8,1,3'b000,18'h0);
        add(1,4'h8,1,3'b000,O_SRC | O_AND); add(1,4'h8,1,3'b000,O_RW);
        add(1,4'h9,1,3'b000,FA); add(1,4'h9,1,3'b000,18'h0);
        add(1,4'h9,1,3'b000,O_SRC | O_OR); add(1,4'h9,1,3'b000,O_RW);
        // LBU, LW, SB
        add(1,4'hA,1,3'b000,FA); add(1,4'hA,1,3'b000,18'h0); add(1,4'hA,1,3'b000,O_SRC);
        add(1,4'hA,1,3'b000,O_REQ | O_BYTE); add(1,4'hA,1,3'b000,O_RW | O_M2R | O_BYTE);
        add(1,4'hD,1,3'b000,FA); add(1,4'hD,1,3'b000,18'h0); add(1,4'hD,1,3'b000,O_SRC);
        add(1,4'hD,1,3'b000,O_REQ); add(1,4'hD,1,3'b000,O_RW | O_M2R);
        add(1,4'hB,1,3'b000,FA); add(1,4'hB,1,3'b000,18'h0); add(1,4'hB,1,3'b000,O_SRC);
        add(1,4'hB,1,3'b000,O_REQ | O_WE | O_BYTE);
        add(1,4'h0,1,3'b000,FA); add(1,4'h0,1,3'b000,18'h0); add(1,4'h0,1,3'b000,O_HALT);
        // Fetch timeout: five unanswered request cycles then FAULT
        add(0,4'h0,0,3'b000,18'h0);
        add(1,4'h0,0,3'b000,18'h0);
        for (int i = 0; i < 5; i++) add(1,4'h0,0,3'b000,FW);
        add(1,4'h0,0,3'b000,O_FLT);
        add(1,4'h0,1,3'b000,O_FLT);
        // Ack on the limit cycle wins
        add(0,4'h8,0,3'b000,18'h0);
        add(1,4'h8,0,3'b000,18'h0);
        for (int i = 0; i < 4; i++) add(1,4'h8,0,3'b000,FW);
        add(1,4'h8,1,3'b000,FA);
        add(1,4'h8,0,3'b000,18'h0);
        add(1,4'h8,0,3'b000,O_SRC | O_AND);
        add(1,4'h8,0,3'b000,O_RW);
        // Data-access timeout on SB
        add(1,4'hB,1,3'b000,FA); add(1,4'hB,1,3'b000,18'h0); add(1,4'hB,1,3'b000,O_SRC);
        for (int i = 0; i < 5; i++) add(1,4'hB,0,3'b000,O_REQ | O_WE | O_BYTE);
        add(1,4'hB,0,3'b000,O_FLT);

        @(negedge clk);
        for (int i = 0; i < vq.size(); i++)
            step($sformatf("vec%0d", i), vq[i].rst, vq[i].op, vq[i].ack, vq[i].flg, vq[i].exp);

        // Reset mid-request in MEM of SB after one wait cycle
        step("sb_rst", 0, 4'hB, 0, 3'b000, 18'h0);
        step("sb_idle", 1, 4'hB, 0, 3'b000, 18'h0);
        step("sb_fetch", 1, 4'hB, 1, 3'b000, FA);
        step("sb_dec", 1, 4'hB, 0, 3'b000, 18'h0);
        step("sb_exec", 1, 4'hB, 0, 3'b000, O_SRC);
        step("sb_mem_wait", 1, 4'hB, 0, 3'b000, O_REQ | O_WE | O_BYTE);
        rst_n = 1'b1; opcode = 4'hB; mem_ack = 1'b0;
        #2;
        chk("sb_mem_req", outs, O_REQ | O_WE | O_BYTE);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_drop", outs, 18'h0);
        @(negedge clk);
        step("rst_hold", 0, 4'hB, 1, 3'b000, 18'h0);
        step("post_rst_idle", 1, 4'hB, 1, 3'b000, 18'h0);
        // Counter must restart from zero after reset: full five-cycle budget again
        for (int i = 0; i < 5; i++)
            step($sformatf("post_rst_wait%0d", i), 1, 4'hB, 0, 3'b000, FW);
        step("post_rst_fault", 1, 4'hB, 0, 3'b000, O_FLT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
